// File: rtl/ap_ctrl_pkg.sv
// ap_ctrl_pkg: array mode codes, command opcodes and sequencer states shared by ap_array_seq.
package ap_ctrl_pkg;
   localparam logic [2:0] MODE_IDLE   = 3'd0;
   localparam logic [2:0] MODE_ROW    = 3'd1;
   localparam logic [2:0] MODE_COL    = 3'd2;
   localparam logic [2:0] MODE_COPY_B = 3'd3;
   localparam logic [2:0] MODE_COPY_R = 3'd4;
   localparam logic [2:0] MODE_COPY_A = 3'd5;
   localparam logic [2:0] MODE_RST0   = 3'd6;
   typedef enum logic [2:0] {
      OP_NOP, OP_WR_ROWS, OP_WR_COLS, OP_RD_ROWS, OP_RD_COLS, OP_COPY_A, OP_COPY_B, OP_CLEAR
   } op_e;
   typedef enum logic [2:0] {S_IDLE, S_WRITE, S_READ, S_DRAIN, S_ONESHOT} state_e;
endpackage

// File: rtl/ap_rd_lat_pipe.sv
// ap_rd_lat_pipe: RD_LAT-deep valid/last shift register tracking reads in flight through the array.
module ap_rd_lat_pipe #(
   parameter int RD_LAT = 2
)(
   input  logic clk,
   input  logic rst,
   input  logic flush,
   input  logic in_valid,
   input  logic in_last,
   output logic out_valid,
   output logic out_last
);
   logic [RD_LAT-1:0] v, l;
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         v <= '0;
         l <= '0;
      end else if (flush) begin
         v <= '0;
         l <= '0;
      end else begin
         v <= RD_LAT'({v, in_valid});
         l <= RD_LAT'({l, in_last});
      end
   end
   assign out_valid = v[RD_LAT-1];
   assign out_last  = l[RD_LAT-1];
endmodule

// File: rtl/ap_array_seq.sv
// ap_array_seq: one-command-at-a-time sequencer owning the control inputs of an AP register array.
// Define AP_SEQ_ABORT_EN to add cmd_abort, which cuts a running write or read short.
module ap_array_seq
   import ap_ctrl_pkg::*;
#(
   parameter int DATA_WIDTH     = 4,
   parameter int DATA_DEPTH     = 4,
   parameter int ADDR_WIDTH_CAM = 8,
   parameter int BUS_W          = 4,
   parameter int RD_LAT         = 2
)(
   input  logic                      clk,
   input  logic                      rst,
`ifdef AP_SEQ_ABORT_EN
   input  logic                      cmd_abort,
`endif
   input  logic                      cmd_valid,
   output logic                      cmd_ready,
   input  logic [2:0]                cmd_op,
   input  logic                      wr_valid,
   output logic                      wr_ready,
   input  logic [BUS_W-1:0]          wr_data,
   output logic                      rd_valid,
   output logic                      rd_last,
   output logic [BUS_W-1:0]          rd_data,
   output logic                      busy,
   output logic [2:0]                input_mode,
   output logic                      rstIn,
   output logic [ADDR_WIDTH_CAM-1:0] addr_input_Row,
   output logic [ADDR_WIDTH_CAM-1:0] addr_input_Col,
   output logic [ADDR_WIDTH_CAM-1:0] addr_output_Row,
   output logic [ADDR_WIDTH_CAM-1:0] addr_output_Col,
   output logic [DATA_WIDTH-1:0]     Ip_row,
   output logic [DATA_DEPTH-1:0]     Ip_col,
   input  logic [DATA_WIDTH-1:0]     Q_out_row,
   input  logic [DATA_DEPTH-1:0]     Q_out_col
);
   localparam logic [ADDR_WIDTH_CAM-1:0] ROW_PARK = ADDR_WIDTH_CAM'(DATA_DEPTH + 3);
   localparam logic [ADDR_WIDTH_CAM-1:0] COL_PARK = ADDR_WIDTH_CAM'(DATA_WIDTH + 3);
   state_e                    state;
   op_e                       op;
   logic [ADDR_WIDTH_CAM-1:0] k;
   logic abort, is_row, st_wr, st_rd, st_dr, st_os, wr_fire, at_last, pv, pl;
   op_e  new_op;
`ifdef AP_SEQ_ABORT_EN
   assign abort = cmd_abort;
`else
   assign abort = 1'b0;
`endif
   assign new_op  = op_e'(cmd_op);
   assign is_row  = (op == OP_WR_ROWS) || (op == OP_RD_ROWS);
   assign st_wr   = state == S_WRITE;
   assign st_rd   = state == S_READ;
   assign st_dr   = state == S_DRAIN;
   assign st_os   = state == S_ONESHOT;
   assign wr_fire = st_wr && wr_valid && !abort;
   assign at_last = k == (is_row ? ADDR_WIDTH_CAM'(DATA_DEPTH - 1) : ADDR_WIDTH_CAM'(DATA_WIDTH - 1));
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= S_IDLE;
         op    <= OP_NOP;
         k     <= '0;
      end else begin
         case (state)
            S_IDLE: if (cmd_valid) begin
               op    <= new_op;
               k     <= '0;
               state <= (new_op == OP_WR_ROWS || new_op == OP_WR_COLS) ? S_WRITE :
                        (new_op == OP_RD_ROWS || new_op == OP_RD_COLS) ? S_READ  :
                        (new_op == OP_NOP) ? S_IDLE : S_ONESHOT;
            end
            S_WRITE: if (abort) begin
               state <= S_IDLE;
               k     <= '0;
            end else if (wr_valid) begin
               state <= at_last ? S_IDLE : S_WRITE;
               k     <= at_last ? '0 : k + 1'b1;
            end
            S_READ: begin
               state <= (at_last || abort) ? S_DRAIN : S_READ;
               k     <= (at_last || abort) ? '0 : k + 1'b1;
            end
            // RD_LAT+1 drain cycles so the final return beat lands inside DRAIN
            S_DRAIN: begin
               state <= (k == ADDR_WIDTH_CAM'(RD_LAT)) ? S_IDLE : S_DRAIN;
               k     <= (k == ADDR_WIDTH_CAM'(RD_LAT)) ? '0 : k + 1'b1;
            end
            default: state <= S_IDLE;
         endcase
      end
   end
   assign cmd_ready       = state == S_IDLE;
   assign busy            = state != S_IDLE;
   assign wr_ready        = st_wr;
   assign input_mode      = (st_wr || st_rd || st_dr) ? (is_row ? MODE_ROW : MODE_COL) :
                            st_os ? ((op == OP_COPY_A) ? MODE_COPY_A :
                                     (op == OP_COPY_B) ? MODE_COPY_B : MODE_RST0) : MODE_IDLE;
   assign rstIn           = st_wr ? !wr_fire : st_os ? (op == OP_CLEAR) : 1'b1;
   assign addr_input_Row  = (st_wr && is_row) ? k : '0;
   assign addr_input_Col  = (st_wr && !is_row) ? k : '0;
   assign addr_output_Row = (st_rd && is_row) ? k : ROW_PARK;
   assign addr_output_Col = (st_rd && !is_row) ? k : COL_PARK;
   assign Ip_row          = (st_wr && is_row) ? wr_data[DATA_WIDTH-1:0] : '0;
   assign Ip_col          = (st_wr && !is_row) ? wr_data[DATA_DEPTH-1:0] : '0;
   ap_rd_lat_pipe #(.RD_LAT(RD_LAT)) u_pipe (
      .clk      (clk),
      .rst      (rst),
      .flush    (state == S_IDLE),
      .in_valid (st_rd),
      .in_last  (st_rd && (at_last || abort)),
      .out_valid(pv),
      .out_last (pl)
   );
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rd_valid <= 1'b0;
         rd_last  <= 1'b0;
         rd_data  <= '0;
      end else begin
         rd_valid <= pv;
         rd_last  <= pl;
         rd_data  <= !pv ? '0 : is_row ? BUS_W'(Q_out_row) : BUS_W'(Q_out_col);
      end
   end
endmodule
